// File: rtl/gate_stimulus_checker.sv
// gate_stimulus_checker: exhaustive 4-bit inverter tester.
// Walks patterns 0..15 onto dut_a, waits SETTLE_CYCLES, then checks that
// dut_y is the bitwise inverse. Reports mismatch count, first failing
// pattern and an overall pass flag.
//
//   state  | meaning
//   -------+---------------------------------------------------------
//   IDLE   | waiting for start; results of last run held stable
//   DRIVE  | register current pattern onto dut_a (one cycle)
//   SETTLE | wait SETTLE_CYCLES cycles for the response to settle
//   CHECK  | compare dut_y with ~dut_a, advance or finish
//   FINISH | pulse done and publish pass on the way back to IDLE
module gate_stimulus_checker #(
    parameter int SETTLE_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       abort,
    output logic [3:0] dut_a,
    input  logic [3:0] dut_y,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [4:0] err_count,
    output logic [3:0] first_fail,
    output logic       first_fail_valid
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        DRIVE  = 3'd1,
        SETTLE = 3'd2,
        CHECK  = 3'd3,
        FINISH = 3'd4
    } state_t;

    // Settle counter is loaded with N-1 so SETTLE lasts exactly N cycles.
    localparam logic [3:0] SETTLE_LOAD =
        (SETTLE_CYCLES > 0) ? 4'(SETTLE_CYCLES - 1) : 4'd0;

    state_t     state;
    state_t     state_nxt;
    logic [3:0] pat_cnt;
    logic [3:0] settle_cnt;
    logic       mismatch;
    logic       run_abort;

    assign mismatch  = (dut_y != ~dut_a);
    assign run_abort = abort && (state != IDLE);
    assign busy      = (state == DRIVE) || (state == SETTLE) || (state == CHECK);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; abort from any active state wins over everything.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start && !abort) state_nxt = DRIVE;
            end
            DRIVE: begin
                state_nxt = (SETTLE_CYCLES == 0) ? CHECK : SETTLE;
            end
            SETTLE: begin
                if (settle_cnt == 4'd0) state_nxt = CHECK;
            end
            CHECK: begin
                state_nxt = (pat_cnt == 4'd15) ? FINISH : DRIVE;
            end
            FINISH: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
        if (run_abort) state_nxt = IDLE;
    end

    // Datapath: pattern/settle counters, stimulus register and result capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pat_cnt          <= 4'd0;
            settle_cnt       <= 4'd0;
            dut_a            <= 4'd0;
            done             <= 1'b0;
            pass             <= 1'b0;
            err_count        <= 5'd0;
            first_fail       <= 4'd0;
            first_fail_valid <= 1'b0;
        end else begin
            done <= 1'b0;
            if (run_abort) begin
                pass <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start && !abort) begin
                            pat_cnt          <= 4'd0;
                            pass             <= 1'b0;
                            err_count        <= 5'd0;
                            first_fail       <= 4'd0;
                            first_fail_valid <= 1'b0;
                        end
                    end
                    DRIVE: begin
                        dut_a      <= pat_cnt;
                        settle_cnt <= SETTLE_LOAD;
                    end
                    SETTLE: begin
                        if (settle_cnt != 4'd0) settle_cnt <= settle_cnt - 4'd1;
                    end
                    CHECK: begin
                        if (mismatch) begin
                            err_count <= err_count + 5'd1;
                            if (!first_fail_valid) begin
                                first_fail       <= dut_a;
                                first_fail_valid <= 1'b1;
                            end
                        end
                        if (pat_cnt != 4'd15) pat_cnt <= pat_cnt + 4'd1;
                    end
                    FINISH: begin
                        done <= 1'b1;
                        pass <= (err_count == 5'd0);
                    end
                    default: begin
                        pat_cnt <= pat_cnt;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_gate_stimulus_checker.sv
// Directed bench for gate_stimulus_checker: good inverter, several faulty
// models, restart-ignore, abort, reset mid-run and a zero-settle build.
module tb_gate_stimulus_checker;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic [3:0] dut_a;
    logic [3:0] dut_y;
    logic       busy, done, pass, first_fail_valid;
    logic [4:0] err_count;
    logic [3:0] first_fail;
    logic [1:0] fault = 2'd0;

    logic       start0 = 1'b0;
    logic       abort0 = 1'b0;
    logic [3:0] dut_a0;
    logic [3:0] dut_y0;
    logic       busy0, done0, pass0, ffv0;
    logic [4:0] err0;
    logic [3:0] ff0;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    // Device-under-test model: 0 good, 1 y[0] stuck-0, 2 y[0] stuck-1, 3 buffer
    always_comb begin
        dut_y = ~dut_a;
        case (fault)
            2'd1:    dut_y = ~dut_a & 4'hE;
            2'd2:    dut_y = ~dut_a | 4'h1;
            2'd3:    dut_y = dut_a;
            default: dut_y = ~dut_a;
        endcase
    end
    assign dut_y0 = ~dut_a0;

    gate_stimulus_checker #(.SETTLE_CYCLES(2)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .dut_a(dut_a), .dut_y(dut_y), .busy(busy), .done(done), .pass(pass),
        .err_count(err_count), .first_fail(first_fail),
        .first_fail_valid(first_fail_valid)
    );

    gate_stimulus_checker #(.SETTLE_CYCLES(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .abort(abort0),
        .dut_a(dut_a0), .dut_y(dut_y0), .busy(busy0), .done(done0), .pass(pass0),
        .err_count(err0), .first_fail(ff0), .first_fail_valid(ffv0)
    );

    // Pulse start for one sampling edge, then watch up to max_cyc edges.
    // done_cyc = edges after the start edge at which done was first seen.
    task automatic run_wait(input int restart_at, input int max_cyc,
                            output int done_cyc, output int done_n);
        done_cyc = -1;
        done_n   = 0;
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int c = 1; c <= max_cyc; c++) begin
            @(posedge clk); #1;
            if (done) begin
                done_n++;
                if (done_cyc < 0) done_cyc = c;
            end
            start = (c == restart_at);
        end
        start = 1'b0;
    endtask

    task automatic test_reset;
        #2;
        total++; if ({busy, done, pass, err_count, first_fail, first_fail_valid, dut_a} !== 17'd0)
            $display("FAIL reset_outputs got=%h want=0",
                     {busy, done, pass, err_count, first_fail, first_fail_valid, dut_a});
        else passed++;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_good_run;
        int dc, dn;
        fault = 2'd0;
        run_wait(-1, 80, dc, dn);
        total++; if (dc !== 65) $display("FAIL good_done_cycle got=%0d want=65", dc); else passed++;
        total++; if (dn !== 1) $display("FAIL good_done_count got=%0d want=1", dn); else passed++;
        total++; if ({pass, err_count, first_fail_valid} !== {1'b1, 5'd0, 1'b0})
            $display("FAIL good_result got pass=%b err=%0d ffv=%b want 1/0/0", pass, err_count, first_fail_valid);
        else passed++;
    endtask

    task automatic test_stuck0;
        int dc, dn;
        fault = 2'd1;
        run_wait(-1, 70, dc, dn);
        total++; if ({pass, err_count, first_fail, first_fail_valid} !== {1'b0, 5'd8, 4'h0, 1'b1})
            $display("FAIL stuck0 got pass=%b err=%0d ff=%h ffv=%b want 0/8/0/1",
                     pass, err_count, first_fail, first_fail_valid);
        else passed++;
    endtask

    task automatic test_stuck1;
        int dc, dn;
        fault = 2'd2;
        run_wait(-1, 70, dc, dn);
        total++; if ({pass, err_count, first_fail, first_fail_valid} !== {1'b0, 5'd8, 4'h1, 1'b1})
            $display("FAIL stuck1 got pass=%b err=%0d ff=%h ffv=%b want 0/8/1/1",
                     pass, err_count, first_fail, first_fail_valid);
        else passed++;
        // results must hold in IDLE
        repeat (10) @(posedge clk);
        #1;
        total++; if ({busy, pass, err_count, first_fail, first_fail_valid} !== {1'b0, 1'b0, 5'd8, 4'h1, 1'b1})
            $display("FAIL idle_hold got busy=%b pass=%b err=%0d ff=%h ffv=%b want 0/0/8/1/1",
                     busy, pass, err_count, first_fail, first_fail_valid);
        else passed++;
    endtask

    task automatic test_buffer;
        int dc, dn;
        fault = 2'd3;
        run_wait(-1, 70, dc, dn);
        total++; if ({pass, err_count, first_fail, first_fail_valid} !== {1'b0, 5'd16, 4'h0, 1'b1})
            $display("FAIL buffer got pass=%b err=%0d ff=%h ffv=%b want 0/16/0/1",
                     pass, err_count, first_fail, first_fail_valid);
        else passed++;
    endtask

    task automatic test_restart_ignored;
        int dc, dn;
        fault = 2'd0;
        run_wait(20, 90, dc, dn);
        total++; if (dc !== 65) $display("FAIL restart_done_cycle got=%0d want=65", dc); else passed++;
        total++; if (dn !== 1) $display("FAIL restart_done_count got=%0d want=1", dn); else passed++;
        total++; if (pass !== 1'b1) $display("FAIL restart_pass got=%b want=1", pass); else passed++;
    endtask

    task automatic test_abort;
        int dn;
        fault = 2'd1;
        dn = 0;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (20) @(posedge clk);   // now in DRIVE of pattern 5
        #1;
        total++; if (busy !== 1'b1) $display("FAIL abort_busy_before got=%b want=1", busy); else passed++;
        abort = 1'b1;
        @(posedge clk); #1 abort = 1'b0;
        total++; if (busy !== 1'b0) $display("FAIL abort_busy_after got=%b want=0", busy); else passed++;
        total++; if ({err_count, first_fail, first_fail_valid, pass} !== {5'd3, 4'h0, 1'b1, 1'b0})
            $display("FAIL abort_partial got err=%0d ff=%h ffv=%b pass=%b want 3/0/1/0",
                     err_count, first_fail, first_fail_valid, pass);
        else passed++;
        for (int c = 0; c < 60; c++) begin
            @(posedge clk); #1;
            if (done) dn++;
        end
        total++; if (dn !== 0) $display("FAIL abort_no_done got=%0d want=0", dn); else passed++;
    endtask

    task automatic test_abort_priority;
        @(posedge clk); #1;
        start = 1'b1; abort = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; abort = 1'b0;
        total++; if (busy !== 1'b0) $display("FAIL abort_priority_busy got=%b want=0", busy); else passed++;
        total++; if (err_count !== 5'd3) $display("FAIL abort_priority_hold got=%0d want=3", err_count); else passed++;
    endtask

    task automatic test_reset_mid_run;
        int dc, dn;
        fault = 2'd3;
        dn = 0;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (30) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        total++; if ({busy, done, pass, err_count, first_fail, first_fail_valid, dut_a} !== 17'd0)
            $display("FAIL reset_mid_outputs got=%h want=0",
                     {busy, done, pass, err_count, first_fail, first_fail_valid, dut_a});
        else passed++;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        for (int c = 0; c < 50; c++) begin
            @(posedge clk); #1;
            if (done || busy) dn++;
        end
        total++; if (dn !== 0) $display("FAIL reset_mid_idle got=%0d want=0", dn); else passed++;
        fault = 2'd0;
        run_wait(-1, 70, dc, dn);
        total++; if (dc !== 65 || pass !== 1'b1)
            $display("FAIL reset_rerun got cycle=%0d pass=%b want 65/1", dc, pass);
        else passed++;
    endtask

    task automatic test_settle_zero;
        int dc;
        dc = -1;
        @(posedge clk); #1 start0 = 1'b1;
        @(posedge clk); #1 start0 = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk); #1;
            if (done0 && dc < 0) dc = c;
        end
        total++; if (dc !== 33) $display("FAIL settle0_done_cycle got=%0d want=33", dc); else passed++;
        total++; if ({pass0, err0, ffv0} !== {1'b1, 5'd0, 1'b0})
            $display("FAIL settle0_result got pass=%b err=%0d ffv=%b want 1/0/0", pass0, err0, ffv0);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_good_run();
        test_stuck0();
        test_stuck1();
        test_buffer();
        test_restart_ignored();
        test_abort();
        test_abort_priority();
        test_reset_mid_run();
        test_settle_zero();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
